game_flow_controller: RTL and testbench

//  Sequences a Pong match around the ball/paddle datapath: start, serve, play, pause, point, game over.

---
 rtl/game_flow_controller_pkg.sv | 17 +
 rtl/game_flow_controller_key_edge_detect.sv | 20 ++
 rtl/game_flow_controller.sv | 124 ++++++++++++
 tb/tb_game_flow_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/game_flow_controller_pkg.sv
// rtl/game_flow_controller_pkg.sv - shared state encodings, key code and player colours
package game_flow_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_POINT     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  localparam logic [3:0] START_CODE     = 4'd5;
  localparam logic [2:0] PLAYER_1_COLOR = 3'b100;
  localparam logic [2:0] PLAYER_2_COLOR = 3'b001;

endpackage

// File: rtl/game_flow_controller_key_edge_detect.sv
// rtl/game_flow_controller_key_edge_detect.sv - one-cycle strobe when a key code first matches the start code
module key_edge_detect #(
  parameter logic [3:0] CODE = 4'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] keys,
  output logic       start
);

  logic [3:0] keys_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) keys_q <= 4'd0;
    else        keys_q <= keys;
  end

  assign start = (keys == CODE) && (keys_q != CODE);

endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - Pong match sequencer: serve, play, pause, point, game over, scores
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter logic [2:0] WIN_SCORE        = 3'd7,
  parameter logic [7:0] POINT_HOLD_TICKS = 8'd60,
  parameter logic [7:0] SERVE_TICKS      = 8'd120
) (
  input  logic       CLOCK_25,
  input  logic       RESET_N,
  input  logic       game_tick,
  input  logic [3:0] keys_1,
  input  logic [3:0] keys_2,
  input  logic       miss_1,
  input  logic       miss_2,
  output logic       pause_active_low,
  output logic       ball_reset,
  output logic       serve_side,
  output logic [2:0] score_1,
  output logic [2:0] score_2,
  output logic [2:0] winner_color,
  output logic [2:0] state
);

  logic       start_1, start_2, any_start, serve_start;
  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] score_1_d, score_2_d, winner_d;
  logic       side_d, ball_reset_d, pause_d;

  key_edge_detect #(.CODE(START_CODE)) u_key_1 (
    .clk(CLOCK_25), .rst_n(RESET_N), .keys(keys_1), .start(start_1)
  );
  key_edge_detect #(.CODE(START_CODE)) u_key_2 (
    .clk(CLOCK_25), .rst_n(RESET_N), .keys(keys_2), .start(start_2)
  );

  assign any_start   = start_1 | start_2;
  assign serve_start = serve_side ? start_2 : start_1;
  assign state       = state_q;

  always_comb begin
    state_d      = state_q;
    score_1_d    = score_1;
    score_2_d    = score_2;
    winner_d     = winner_color;
    side_d       = serve_side;
    ball_reset_d = 1'b0;
    case (state_q)
      ST_IDLE: if (any_start) begin
        state_d      = ST_SERVE;
        score_1_d    = 3'd0;
        score_2_d    = 3'd0;
        ball_reset_d = 1'b1;
      end
      ST_SERVE: if (serve_start || (game_tick && timer_q == SERVE_TICKS - 8'd1))
        state_d = ST_PLAY;
      ST_PLAY: begin
        if (miss_1 && miss_2) begin
          state_d = ST_POINT;
        end else if (miss_1) begin
          state_d = ST_POINT;
          side_d  = 1'b0;
          if (score_2 != WIN_SCORE) score_2_d = score_2 + 3'd1;
        end else if (miss_2) begin
          state_d = ST_POINT;
          side_d  = 1'b1;
          if (score_1 != WIN_SCORE) score_1_d = score_1 + 3'd1;
        end else if (any_start) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: if (any_start) state_d = ST_PLAY;
      ST_POINT: if (game_tick && timer_q == POINT_HOLD_TICKS - 8'd1) begin
        if (score_1 == WIN_SCORE) begin
          state_d  = ST_GAME_OVER;
          winner_d = PLAYER_1_COLOR;
        end else if (score_2 == WIN_SCORE) begin
          state_d  = ST_GAME_OVER;
          winner_d = PLAYER_2_COLOR;
        end else begin
          state_d      = ST_SERVE;
          ball_reset_d = 1'b1;
        end
      end
      // The loser of the last point keeps the serve into the new match.
      ST_GAME_OVER: if (any_start) begin
        state_d      = ST_SERVE;
        score_1_d    = 3'd0;
        score_2_d    = 3'd0;
        winner_d     = 3'd0;
        ball_reset_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    pause_d = (state_d != ST_PLAY);
    if (state_d != state_q) timer_d = 8'd0;
    else if (game_tick)     timer_d = timer_q + 8'd1;
    else                    timer_d = timer_q;
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q          <= ST_IDLE;
      timer_q          <= 8'd0;
      score_1          <= 3'd0;
      score_2          <= 3'd0;
      winner_color     <= 3'd0;
      serve_side       <= 1'b0;
      ball_reset       <= 1'b0;
      pause_active_low <= 1'b1;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      score_1          <= score_1_d;
      score_2          <= score_2_d;
      winner_color     <= winner_d;
      serve_side       <= side_d;
      ball_reset       <= ball_reset_d;
      pause_active_low <= pause_d;
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - directed scoreboard bench for game_flow_controller
module tb_game_flow_controller;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_PAUSED = 3'd3,
                         S_POINT = 3'd4, S_GO = 3'd5;
  localparam logic [2:0] P1_COLOR = 3'b100, P2_COLOR = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_tick = 1'b0;
  logic [3:0] keys_1 = 4'd0, keys_2 = 4'd0;
  logic       miss_1 = 1'b0, miss_2 = 1'b0;
  logic       pause_active_low, ball_reset, serve_side;
  logic [2:0] score_1, score_2, winner_color, state;

  game_flow_controller dut (
    .CLOCK_25(clk), .RESET_N(rst_n), .game_tick(game_tick),
    .keys_1(keys_1), .keys_2(keys_2), .miss_1(miss_1), .miss_2(miss_2),
    .pause_active_low(pause_active_low), .ball_reset(ball_reset), .serve_side(serve_side),
    .score_1(score_1), .score_2(score_2), .winner_color(winner_color), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pause;
    logic       br;
    logic       side;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] win;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  logic       g_side = 1'b0;
  logic [2:0] g_s1 = 3'd0, g_s2 = 3'd0;

  task automatic chk(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] st, input logic br, input logic [2:0] win);
    exp_t e;
    e.st = st; e.pause = (st != S_PLAY); e.br = br; e.side = g_side;
    e.s1 = g_s1; e.s2 = g_s2; e.win = win;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "state", {5'd0, state}, {5'd0, e.st});
    chk(t, "pause", {7'd0, pause_active_low}, {7'd0, e.pause});
    chk(t, "ball_reset", {7'd0, ball_reset}, {7'd0, e.br});
    chk(t, "serve_side", {7'd0, serve_side}, {7'd0, e.side});
    chk(t, "score_1", {5'd0, score_1}, {5'd0, e.s1});
    chk(t, "score_2", {5'd0, score_2}, {5'd0, e.s2});
    chk(t, "winner", {5'd0, winner_color}, {5'd0, e.win});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic br, input logic [2:0] win);
    push(tag, st, br, win);
    step();
    compare();
  endtask

  task automatic serve_key();
    if (g_side) keys_2 = 4'd5; else keys_1 = 4'd5;
    cyc("serve_key", S_PLAY, 1'b0, 3'd0);
    keys_1 = 4'd0;
    keys_2 = 4'd0;
    cyc("play_idle", S_PLAY, 1'b0, 3'd0);
  endtask

  task automatic miss(input logic m1, input logic m2);
    miss_1 = m1;
    miss_2 = m2;
    if (m1 && !m2) begin g_s2 = g_s2 + 3'd1; g_side = 1'b0; end
    if (m2 && !m1) begin g_s1 = g_s1 + 3'd1; g_side = 1'b1; end
    cyc("miss", S_POINT, 1'b0, 3'd0);
    miss_1 = 1'b0;
    miss_2 = 1'b0;
  endtask

  task automatic hold();
    game_tick = 1'b1;
    miss_1 = 1'b1;
    step();
    miss_1 = 1'b0;
    for (int i = 0; i < 57; i++) step();
    cyc("hold_59", S_POINT, 1'b0, 3'd0);
    if (g_s1 == 3'd7)      cyc("hold_end_go", S_GO, 1'b0, P1_COLOR);
    else if (g_s2 == 3'd7) cyc("hold_end_go", S_GO, 1'b0, P2_COLOR);
    else begin
      cyc("hold_end_serve", S_SERVE, 1'b1, 3'd0);
      game_tick = 1'b0;
      cyc("serve_br_end", S_SERVE, 1'b0, 3'd0);
    end
    game_tick = 1'b0;
  endtask

  initial begin
    step();
    step();
    push("reset", S_IDLE, 1'b0, 3'd0);
    compare();
    rst_n = 1'b1;
    step();

    keys_1 = 4'd5;
    cyc("start", S_SERVE, 1'b1, 3'd0);
    keys_1 = 4'd0;
    cyc("start_pulse_end", S_SERVE, 1'b0, 3'd0);

    keys_2 = 4'd5;
    cyc("nonserver_key", S_SERVE, 1'b0, 3'd0);
    keys_2 = 4'd0;
    game_tick = 1'b1;
    for (int i = 0; i < 118; i++) step();
    cyc("serve_tick_119", S_SERVE, 1'b0, 3'd0);
    cyc("auto_serve", S_PLAY, 1'b0, 3'd0);
    game_tick = 1'b0;

    miss(1'b0, 1'b1);
    hold();

    for (int r = 0; r < 7; r++) begin
      serve_key();
      miss(1'b1, 1'b0);
      hold();
    end
    cyc("game_over_hold", S_GO, 1'b0, P2_COLOR);
    keys_1 = 4'd5;
    g_s1 = 3'd0;
    g_s2 = 3'd0;
    cyc("restart", S_SERVE, 1'b1, 3'd0);
    keys_1 = 4'd0;
    cyc("restart_br_end", S_SERVE, 1'b0, 3'd0);

    serve_key();
    keys_1 = 4'd5;
    miss(1'b1, 1'b1);
    keys_1 = 4'd0;
    hold();

    serve_key();
    keys_1 = 4'd5;
    cyc("pause_toggle", S_PAUSED, 1'b0, 3'd0);
    for (int i = 0; i < 98; i++) step();
    miss_1 = 1'b1;
    cyc("paused_held_miss", S_PAUSED, 1'b0, 3'd0);
    miss_1 = 1'b0;
    keys_1 = 4'd0;
    cyc("key_release", S_PAUSED, 1'b0, 3'd0);
    keys_1 = 4'd5;
    cyc("resume", S_PLAY, 1'b0, 3'd0);
    keys_1 = 4'd0;
    miss(1'b1, 1'b0);
    game_tick = 1'b1;
    for (int i = 0; i < 10; i++) step();
    game_tick = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    g_side = 1'b0;
    g_s1 = 3'd0;
    g_s2 = 3'd0;
    push("async_reset", S_IDLE, 1'b0, 3'd0);
    compare();
    step();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
